// File: rtl/gray_to_bin_seq.sv
// gray_to_bin_seq: bit-serial Gray-to-binary decoder.
// A Gray word is accepted over a valid/ready handshake. It is resolved MSB-first,
// one bit per clock, and the binary result is offered on an output valid/ready
// handshake. In DONE the block can release the result and accept a new word in
// the same cycle.
module gray_to_bin_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] gray_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] bin_out,
   output logic             busy
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_g;
   logic [WIDTH-1:0] w_g_nxt;
   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] w_bin_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   logic             w_accept;
   logic [WIDTH-1:0] w_bin_above;

   // Handshake outputs depend only on the state and out_ready. They never depend on gray_in.
   assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_CONVERT);
   assign bin_out   = r_bin;
   assign w_accept  = in_valid & in_ready;

   // bin[idx+1] is read at position idx. The shift fills the MSB with 0, so the
   // top bit needs no special case.
   assign w_bin_above = r_bin >> 1;

   // Next-state logic: accept or re-accept a word, resolve one bit per cycle, release in DONE
   always_comb begin
      w_state_nxt = r_state;
      w_g_nxt     = r_g;
      w_bin_nxt   = r_bin;
      w_idx_nxt   = r_idx;
      case (r_state)
         S_CONVERT: begin
            w_bin_nxt[r_idx] = r_g[r_idx] ^ w_bin_above[r_idx];
            if (r_idx == '0) begin
               w_state_nxt = S_DONE;
            end else begin
               w_idx_nxt = r_idx - IDX_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // An accept overrides the DONE release. This gives back-to-back re-accept.
      if (w_accept) begin
         w_g_nxt     = gray_in;
         w_bin_nxt   = '0;
         w_idx_nxt   = IDX_LAST;
         w_state_nxt = S_CONVERT;
      end
   end

   // State and datapath registers. An asynchronous reset discards any word in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_g     <= '0;
         r_bin   <= '0;
         r_idx   <= IDX_LAST;
      end else begin
         r_state <= w_state_nxt;
         r_g     <= w_g_nxt;
         r_bin   <= w_bin_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

endmodule

// File: tb/tb_gray_to_bin_seq.sv
// Testbench for gray_to_bin_seq (WIDTH=4). It uses directed and random decodes
// checked against an XOR-prefix reference model.
module tb_gray_to_bin_seq;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] gray_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] bin_out;
   logic         busy;

   int total = 0;
   int bad   = 0;

   gray_to_bin_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .gray_in   (gray_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bin_out   (bin_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: each binary bit is the XOR of all Gray bits at and above it.
   function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = ^(g >> i);
      return r;
   endfunction

   function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Accept g (bounded wait for in_ready), then follow the conversion:
   // 4 busy cycles with correct partial bits, DONE with the result, an optional
   // stall, and then release. If junk is set, gray_in and in_valid are toggled
   // during CONVERT, and this must have no effect.
   task automatic do_decode(input logic [W-1:0] g, input logic [W-1:0] exp,
                            input int stall, input bit junk, input string tag);
      int n;
      logic [W-1:0] mask;
      out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) chk({tag, "_wait_in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      gray_in  = g;
      tick();
      in_valid = 1'b0;
      for (int j = 0; j < W; j++) begin
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_nvalid"}, out_valid, 0);
         mask = ~({W{1'b1}} >> j);
         chk({tag, "_partial"}, bin_out, exp & mask);
         if (junk) begin
            in_valid = 1'b1;
            gray_in  = W'($urandom);
         end
         tick();
      end
      in_valid = 1'b0;
      chk({tag, "_out_valid"}, out_valid, 1);
      chk({tag, "_busy_done"}, busy, 0);
      chk({tag, "_bin"}, bin_out, exp);
      if (stall > 0) begin
         out_ready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            tick();
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_bin"}, bin_out, exp);
         end
         out_ready = 1'b1;
      end
      tick();
      chk_idle({tag, "_released"});
   endtask

   initial begin
      int cyc;
      logic [W-1:0] g;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      gray_in   = '0;

      // Reset values
      repeat (3) tick();
      chk_idle("reset");
      chk("reset_bin", bin_out, 0);
      rst_n = 1'b1;
      tick();
      chk_idle("after_reset");

      // Directed single decodes
      do_decode(4'b0110, 4'b0100, 0, 1'b0, "d0110");
      do_decode(4'b1010, 4'b1100, 0, 1'b0, "d1010");
      do_decode(4'b1000, 4'b1111, 0, 1'b0, "d1000");
      do_decode(4'b0000, 4'b0000, 0, 1'b0, "d0000");

      // Exhaustive back-to-back round trip, re-accepting in every DONE cycle
      out_ready = 1'b1;
      in_valid  = 1'b1;
      gray_in   = b2g(4'd0);
      cyc = 0;
      tick();
      for (int b = 0; b < 16; b++) begin
         repeat (W) begin
            tick();
            cyc++;
         end
         chk("rt_valid", out_valid, 1);
         chk("rt_bin", bin_out, b);
         chk("rt_in_ready", in_ready, 1);
         if (b < 15) gray_in = b2g(W'(b + 1));
         else in_valid = 1'b0;
         tick();
         cyc++;
      end
      chk("rt_cycles", cyc, 16 * (W + 1));
      chk_idle("rt_end");

      // Backpressure with a pending word that is accepted at release
      out_ready = 1'b0;
      in_valid  = 1'b1;
      gray_in   = 4'b1111;
      tick();
      in_valid = 1'b0;
      repeat (W) tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_bin", bin_out, 4'b1010);
      in_valid = 1'b1;
      gray_in  = 4'b0001;
      for (int s = 0; s < 6; s++) begin
         #1;
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_bin", bin_out, 4'b1010);
         chk("bp_in_ready", in_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("bp_reaccept_busy", busy, 1);
      chk("bp_reaccept_nvalid", out_valid, 0);
      repeat (W - 1) tick();
      chk("bp2_nvalid", out_valid, 0);
      tick();
      chk("bp2_valid", out_valid, 1);
      chk("bp2_bin", bin_out, 4'b0001);
      tick();
      chk_idle("bp2_released");

      // Input changes during conversion are ignored
      do_decode(4'b0110, 4'b0100, 0, 1'b1, "midchg");

      // Asynchronous reset during the second CONVERT cycle
      in_valid = 1'b1;
      gray_in  = 4'b1000;
      tick();
      in_valid = 1'b0;
      tick();
      chk("rst_pre_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle("rst_async");
      chk("rst_async_bin", bin_out, 0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rst_no_valid", out_valid, 0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rst_after_no_valid", out_valid, 0);
      end
      do_decode(4'b0011, 4'b0010, 0, 1'b0, "post_rst");

      // Random decodes with random stalls, checked against the model
      for (int r = 0; r < 24; r++) begin
         g = W'($urandom_range(0, 15));
         do_decode(g, g2b(g), int'($urandom_range(0, 3)), r[0], "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time bound so that a stuck run still terminates.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gray_to_bin_seq.md
# gray_to_bin_seq

Sequential Gray-to-binary decoder, the receive-side counterpart of the team's binary-to-Gray encoder. It accepts a WIDTH-bit Gray word over a valid/ready handshake and resolves it MSB-first, one bit per clock. It presents the binary result on a second valid/ready handshake, so Gray-coded counters and position values can be decoded with a single XOR stage.

## Interface
- WIDTH, 4, Gray/binary word width (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  gray_in holds a word to decode
- in_ready  output  1  block can accept a word this cycle
- gray_in  input  WIDTH  Gray-coded input word
- out_valid  output  1  bin_out holds a completed result
- out_ready  input  1  downstream consumes result this cycle
- bin_out  output  WIDTH  binary result
- busy  output  1  high in CONVERT state

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, CONVERT, DONE. Internal registers: g_reg[WIDTH], bin_reg[WIDTH], idx (clog2(WIDTH) bits, minimum 1).
- bin_out = bin_reg. out_valid = (state==DONE). busy = (state==CONVERT).
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept = in_valid & in_ready. On accept:
  - g_reg ← gray_in
  - bin_reg ← 0
  - idx ← WIDTH-1
  - state ← CONVERT
- CONVERT, each cycle:
  - bin_reg[idx] ← g_reg[idx] ^ (idx==WIDTH-1 ? 0 : bin_reg[idx+1])
  - if idx==0, state ← DONE; else idx ← idx-1
- DONE:
  - holds bin_reg and out_valid until out_ready.
  - out_ready & !in_valid → IDLE.
  - out_ready & in_valid → accept the new word directly, go to CONVERT. This is a simultaneous release and accept.
- in_valid during CONVERT is ignored (in_ready=0). gray_in is sampled only on the accept edge; later changes have no effect.
- Result: bin[i] = XOR of gray[WIDTH-1:i], the exact inverse of bin→Gray (g[i] = b[i]^b[i+1], g[MSB] = b[MSB]).
- No arithmetic overflow is possible. All-ones and all-zeros inputs are legal. idx wrap below 0 never occurs because state leaves CONVERT at idx==0.
- Reset (asynchronous, at any time, including mid-CONVERT or in DONE): the in-flight word is discarded and not output.
  - state=IDLE, g_reg=0, bin_reg=0, idx=WIDTH-1
  - in_ready=1, out_valid=0, busy=0, bin_out=0
- Valid signals are never dropped by the block once asserted: out_valid stays high until the handshake completes.

## Timing
- Latency: out_valid rises exactly WIDTH clock edges after the accept edge. For WIDTH=4: 4 cycles.
- During CONVERT, bin_out shows partial result. Bits above idx are final; bits at and below idx are 0.
- Throughput:
  - One word per WIDTH+1 cycles with out_ready held high (DONE-cycle re-accept).
  - One word per WIDTH+2 cycles if the new in_valid arrives after the release.
- in_ready and out_valid are combinational from state/out_ready only. There is no combinational path from gray_in to any output.
- Reset is asserted asynchronously and deasserted synchronously externally. The first accept can occur on the first rising edge after rst_n goes high.

## Test plan
- Reset values: hold rst_n=0 → in_ready=1, out_valid=0, busy=0, bin_out=4'b0000.
- Single decodes (WIDTH=4, out_ready=1): each result appears with out_valid exactly 4 cycles after accept, and busy is high for exactly 4 cycles.
  - gray 4'b0110 → bin 4'b0100
  - gray 4'b1010 → 4'b1100
  - gray 4'b1000 → 4'b1111
  - gray 4'b0000 → 4'b0000
- Exhaustive round trip: drive gray(b) = b^(b>>1) for b=0..15 back-to-back with out_ready=1.
  - Each bin_out equals b.
  - Every DONE cycle with in_valid=1 re-accepts, so 16 results complete in 16×5 cycles.
- Backpressure: gray 4'b1111 (→4'b1010) with out_ready=0 for 6 cycles.
  - out_valid and bin_out=4'b1010 held stable.
  - in_ready=0 throughout, and a concurrent in_valid with gray_in 4'b0001 is not accepted.
  - Raising out_ready → released; the pending word is then accepted in the same cycle and decodes to 4'b0001.
- Input changes mid-conversion: accept 4'b0110, then change gray_in to 4'b1111 during CONVERT → result still 4'b0100.
- Reset mid-operation: assert rst_n=0 during the second CONVERT cycle of 4'b1000.
  - Outputs return to reset values immediately (asynchronously).
  - No out_valid ever appears for that word.
  - The next accepted word 4'b0011 decodes to 4'b0010.
